// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - stall, flush and forwarding control for the five-stage ARM pipeline
module hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       WA3D,
  input  logic             MemtoRegE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             PCSrcD,
  input  logic             PCSrcE,
  input  logic             PCSrcM,
  input  logic             PCSrcW,
  input  logic             BranchTakenE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] LdStallCnt
);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  logic [3:0] ra1_e, ra2_e, wa3_e, wa3_m, wa3_w;
  logic       ldr_stall;
  logic       pc_wr_pending_f;
  logic       flush_e_raw;
  logic [1:0] fwd_a_raw, fwd_b_raw;

  // Forwarding select for one Execute source; Memory wins over Writeback and
  // R15 is never forwarded because the datapath supplies PC+8 for it.
  function automatic logic [1:0] fwd_sel(input logic [3:0] ra_e,
                                         input logic [3:0] wa_m,
                                         input logic [3:0] wa_w,
                                         input logic       rw_m,
                                         input logic       rw_w);
    logic [1:0] sel;
    sel = FWD_RF;
    if (ra_e != 4'd15) begin
      if (rw_m && (ra_e == wa_m))
        sel = FWD_MEM;
      else if (rw_w && (ra_e == wa_w))
        sel = FWD_WB;
    end
    return sel;
  endfunction

  // Raw hazard terms, independent of reset forcing.
  always_comb begin
    ldr_stall       = MemtoRegE & ((RA1D == wa3_e) | (RA2D == wa3_e));
    pc_wr_pending_f = PCSrcD | PCSrcE | PCSrcM;
    flush_e_raw     = ldr_stall | BranchTakenE;
    fwd_a_raw       = fwd_sel(ra1_e, wa3_m, wa3_w, RegWriteM, RegWriteW);
    fwd_b_raw       = fwd_sel(ra2_e, wa3_m, wa3_w, RegWriteM, RegWriteW);
  end

  // Outputs to the controller/datapath; reset forces a flushed, unstalled pipe.
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    FlushD    = 1'b1;
    FlushE    = 1'b1;
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (!reset) begin
      StallF    = ldr_stall | pc_wr_pending_f;
      StallD    = ldr_stall;
      FlushD    = pc_wr_pending_f | PCSrcW | BranchTakenE;
      FlushE    = flush_e_raw;
      ForwardAE = fwd_a_raw;
      ForwardBE = fwd_b_raw;
    end
  end

  // Register-address pipeline mirroring the controller's stage registers; E
  // takes a bubble on flush, M and W always advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      ra1_e <= 4'd0;
      ra2_e <= 4'd0;
      wa3_e <= 4'd0;
      wa3_m <= 4'd0;
      wa3_w <= 4'd0;
    end else begin
      if (flush_e_raw) begin
        ra1_e <= 4'd0;
        ra2_e <= 4'd0;
        wa3_e <= 4'd0;
      end else begin
        ra1_e <= RA1D;
        ra2_e <= RA2D;
        wa3_e <= WA3D;
      end
      wa3_m <= wa3_e;
      wa3_w <= wa3_m;
    end
  end

  // Saturating count of load-use stall cycles.
  always_ff @(posedge clk) begin
    if (reset)
      LdStallCnt <= '0;
    else if (ldr_stall && (LdStallCnt != {CNT_W{1'b1}}))
      LdStallCnt <= LdStallCnt + {{(CNT_W-1){1'b0}}, 1'b1};
  end

endmodule
